linear_search_ctrl: RTL
=======================

# linear_search_ctrl

Sequencing controller that owns the data memory's read port for hardware linear searches and shares the memory with the CPU datapath. On a start pulse it scans `length` consecutive words from `base_addr`, one word per cycle, and compares each against `key`. It reports the first matching offset, or no match. It sits between the CPU load/store path and `data_mem`. The CPU has the memory when the controller is idle and is stalled while a scan is running.

## Interface
- `AW`, default 10: word-address width of the attached memory; index width is AW, length width is AW+1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: search request; accepted only in IDLE.
- `key` in 32: value searched for; latched on accept.
- `base_addr` in 32: byte address of the first word; bits [1:0] ignored; latched on accept.
- `length` in AW+1: number of words to scan, 0..2^AW; latched on accept.
- `busy` out 1: high in SCAN.
- `done` out 1: one-cycle completion pulse.
- `found` out 1: match flag; valid from the `done` cycle until the next accept.
- `index` out AW: word offset from base of the first match; 0 when no match.
- `cpu_mem_read`, `cpu_mem_write` in 1 each: CPU memory requests.
- `cpu_addr`, `cpu_wdata` in 32 each: CPU byte address and store data.
- `cpu_rdata` out 32: load data returned to the CPU.
- `cpu_stall` out 1: CPU request blocked this cycle.
- `mem_read`, `mem_write` out 1 each: driven to the data memory.
- `mem_addr`, `mem_wdata` out 32 each: driven to the data memory.
- `mem_rdata` in 32: combinational read data from the memory.

## Operation
- FSM states are IDLE, SCAN and DONE.
- **IDLE**
  - Memory port passes the CPU through: `mem_*` = `cpu_*`, `cpu_rdata` = `mem_rdata`, `cpu_stall` = 0.
  - `start` with `length` != 0: latch key, base (word-aligned), and length; clear cnt; go to SCAN.
  - `start` with `length` == 0: clear `found` and `index`; go to DONE with no memory access.
- **SCAN**
  - Drives `mem_read` = 1, `mem_write` = 0, `mem_addr` = base + (cnt << 2), computed mod 2^32. The memory decodes only addr[AW+1:2], so the scan wraps within the memory.
  - CPU is blocked: `cpu_stall` = `cpu_mem_read` | `cpu_mem_write`, `cpu_rdata` = 0.
  - If `mem_rdata` == key: `found` <= 1, `index` <= cnt, go to DONE.
  - Else if cnt == len−1: `found` <= 0, `index` <= 0, go to DONE.
  - Else cnt <= cnt + 1.
- **DONE**: `done` = 1, `busy` = 0, CPU passthrough as in IDLE; unconditionally return to IDLE.
- Duplicate matches: the lowest offset wins.
- `start` outside IDLE is ignored; there is no queueing.
- `start` and a CPU access in the same IDLE cycle: the CPU access completes that cycle, and the controller takes the port on the next cycle.
- Comparison is a full 32-bit unsigned equality.

## Timing
- Reset values: state IDLE; `busy`, `done`, `found` = 0; `index` = 0; cnt = 0. After reset, `mem_*` simply follow the CPU inputs.
- With `start` accepted at edge E0:
  - Word k is compared in the cycle after edge E0+k.
  - A match at offset k raises `done` in the cycle after edge E0+k+1.
  - No match with length L raises `done` in the cycle after edge E0+L.
  - `length` == 0 raises `done` in the cycle after E0+1.
- Worst-case latency is 2^AW + 1 cycles.
- `rst` mid-SCAN: at the next edge the FSM returns to IDLE, with no `done` pulse and `found`/`index` cleared.
- `busy` and `done` are never high together.
- `found` and `index` are registered and stable outside SCAN.

## Structure
- Package `search_pkg` holds:
  - the state enum (IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2);
  - `WORD_BYTES` = 4.
- Sub-module `mem_port_mux`: a purely combinational CPU/controller mux selected by the `busy` state. It generates `mem_*`, `cpu_rdata` and `cpu_stall`.
- FSM, counter and result registers live in the top module.

## Test plan
- **Match:** memory words 0..4 = 0..4; start with base 0, length 5, key 3 -> `mem_addr` 0, 4, 8, 12; `done` after E0+4; `found` = 1, `index` = 3.
- **No match:** same memory, key 9 -> `mem_addr` 0..16; `done` after E0+5; `found` = 0, `index` = 0.
- **Zero length:** `length` 0 -> `mem_read` never driven by the controller; `done` after E0+1; `found` = 0.
- **Arbitration:** CPU store to address 8 during SCAN -> `cpu_stall` = 1, `mem_write` = 0. The same store is retried in the DONE cycle -> `mem_write` = 1, `mem_addr` = 8.
- **Duplicates and ignored start:** words 2 and 4 = 7; key 7, base 0, length 5 -> `index` = 2. A second `start` during SCAN is ignored, and exactly one `done` pulse occurs.
- **Reset abort:** `rst` pulsed in the second SCAN cycle -> `busy` = 0 next cycle, no `done`, `found` = 0, `index` = 0; a new start then runs normally.

Source files
------------

// File: rtl/linear_search_ctrl_pkg.sv
// Shared types and constants for the linear search controller slice.
package search_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Byte address of a word offset from a word-aligned base, wrapping mod 2^32.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] word_off);
    word_byte_addr = base + (word_off * 32'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/linear_search_ctrl_mem_port_mux.sv
// Combinational ownership mux for the data memory port: CPU when the
// controller is not scanning, controller read stream while it is.
module mem_port_mux (
  input  logic        sel_ctrl,
  input  logic        ctrl_read,
  input  logic [31:0] ctrl_addr,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Route the memory port to the controller while scanning, else to the CPU.
  always_comb begin
    mem_read  = cpu_mem_read;
    mem_write = cpu_mem_write;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_rdata = mem_rdata;
    cpu_stall = 1'b0;
    if (sel_ctrl) begin
      mem_read  = ctrl_read;
      mem_write = 1'b0;
      mem_addr  = ctrl_addr;
      mem_wdata = 32'd0;
      cpu_rdata = 32'd0;
      cpu_stall = cpu_mem_read | cpu_mem_write;
    end else begin
      cpu_stall = 1'b0;
    end
  end

endmodule

// File: rtl/linear_search_ctrl.sv
// Hardware linear search sequencer sharing the data memory with the CPU.
// Scans `length` words from `base_addr`, one per cycle, and reports the
// lowest matching offset.
module linear_search_ctrl
  import search_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [31:0]   key,
  input  logic [31:0]   base_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [AW-1:0] index,
  input  logic          cpu_mem_read,
  input  logic          cpu_mem_write,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [AW:0]   LEN_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_e        state_r;
  logic [AW-1:0] cnt_r;
  logic [AW:0]   len_r;
  logic [31:0]   key_r;
  logic [31:0]   base_r;
  logic          busy_r;
  logic          done_r;
  logic          found_r;
  logic [AW-1:0] index_r;
  // A zero-length request waits one idle cycle so it completes with the
  // same latency as a one-word scan, without touching the memory.
  logic          zero_pend_r;

  logic [31:0]   scan_addr_s;
  logic          hit_s;
  logic          last_word_s;

  assign scan_addr_s = word_byte_addr(base_r, 32'(cnt_r));
  assign hit_s       = (mem_rdata == key_r);
  assign last_word_s = ({1'b0, cnt_r} == (len_r - LEN_ONE));

  assign busy  = busy_r;
  assign done  = done_r;
  assign found = found_r;
  assign index = index_r;

  // Sequencing FSM, word counter and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {AW{1'b0}};
      len_r       <= {(AW+1){1'b0}};
      key_r       <= 32'd0;
      base_r      <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      found_r     <= 1'b0;
      index_r     <= {AW{1'b0}};
      zero_pend_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (zero_pend_r) begin
            zero_pend_r <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= DONE;
          end else if (start) begin
            if (length != {(AW+1){1'b0}}) begin
              key_r   <= key;
              base_r  <= {base_addr[31:2], 2'b00};
              len_r   <= length;
              cnt_r   <= {AW{1'b0}};
              busy_r  <= 1'b1;
              state_r <= SCAN;
            end else begin
              found_r     <= 1'b0;
              index_r     <= {AW{1'b0}};
              zero_pend_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (hit_s) begin
            found_r <= 1'b1;
            index_r <= cnt_r;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else if (last_word_s) begin
            found_r <= 1'b0;
            index_r <= {AW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          zero_pend_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  mem_port_mux u_mux (
    .sel_ctrl      (busy_r),
    .ctrl_read     (busy_r),
    .ctrl_addr     (scan_addr_s),
    .cpu_mem_read  (cpu_mem_read),
    .cpu_mem_write (cpu_mem_write),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

endmodule
